// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg -- shared types and helpers for the round-robin lock arbiter.
//   arb_state_e : FSM state encoding (IDLE, GRANT)
//   CNT_W       : width of the hold counter used by the optional timeout
//   MAX_N       : largest supported requester count
//   oh_to_idx   : one-hot to binary index conversion (up to MAX_N bits)
package rr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int CNT_W = 8;
  localparam int MAX_N = 32;

  // OR-reduction of the set-bit positions; exact for a one-hot or zero input.
  function automatic logic [4:0] oh_to_idx(input logic [MAX_N-1:0] oh);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = idx | 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// rr_arb_pick -- combinational round-robin winner search.
// Scans req starting at ptr+1 and wrapping modulo N; ptr itself is checked last.
// Ports:
//   req   [N-1:0]  request vector
//   ptr   [IW-1:0] index of the most recent winner
//   found          at least one request is set
//   idx   [IW-1:0] winner index (0 when nothing is found)
//   oh    [N-1:0]  one-hot winner (zero when nothing is found)
module rr_arb_pick
  import rr_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  oh
);

  always_comb begin
    found = 1'b0;
    oh    = '0;
    for (int k = 1; k <= N; k++) begin
      int            pos;
      logic [IW-1:0] sel;
      // ptr < N and k <= N, so one subtraction is enough to wrap.
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      sel = IW'(pos);
      if (!found && req[sel]) begin
        found   = 1'b1;
        oh[sel] = 1'b1;
      end
    end
  end

  assign idx = IW'(oh_to_idx(MAX_N'(oh)));

endmodule

// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter -- N-way round-robin arbiter with grant locking.
// Rotation follows the last winner; an owner keeps the grant until it drops
// its request or pulses arb_done, then re-arbitration happens in the same
// cycle so the next owner appears on the following edge.
// Optional build macro RR_ARB_TIMEOUT_EN adds an 8-bit hold counter that
// forces a handover after HOLD_MAX grant cycles when others are waiting.
// Ports:
//   arb_clk      clock, rising edge
//   arb_rst_n    asynchronous active-low reset
//   arb_req      [N-1:0]  request vector
//   arb_done     owner's last beat (ignored while idle)
//   arb_gnt_vld  a grant is active
//   arb_gnt_oh   [N-1:0]  one-hot grant, zero when idle
//   arb_gnt_id   [IW-1:0] owner index, holds last value when idle
//   pointer      [IW-1:0] most recent winner
//   arb_preempt  one-cycle pulse when a timeout forced the handover
module rr_lock_arbiter
  import rr_arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int HOLD_MAX = 16,
  localparam int IW       = $clog2(N)
) (
  input  logic          arb_clk,
  input  logic          arb_rst_n,
  input  logic [N-1:0]  arb_req,
  input  logic          arb_done,
  output logic          arb_gnt_vld,
  output logic [N-1:0]  arb_gnt_oh,
  output logic [IW-1:0] arb_gnt_id,
  output logic [IW-1:0] pointer,
  output logic          arb_preempt
);

  arb_state_e    state;
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [N-1:0]  win_oh;
  logic          release_c;
  logic          forced;
  logic          take;

  rr_arb_pick #(.N(N)) u_pick (
    .req   (arb_req),
    .ptr   (pointer),
    .found (win_found),
    .idx   (win_idx),
    .oh    (win_oh)
  );

  assign release_c = (state == GRANT) && (arb_done || !arb_req[arb_gnt_id]);

`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] hold_cnt;
  logic             others;

  assign others = |(arb_req & ~arb_gnt_oh);
  // Owner stays lowest priority on a forced handover because pointer
  // already equals the owner, so the search reaches it last.
  assign forced = (state == GRANT) && !release_c && (hold_cnt == HOLD_LIM) && others;

  // Clears on every new grant, saturates at HOLD_LIM while unopposed.
  always_ff @(posedge arb_clk or negedge arb_rst_n) begin
    if (!arb_rst_n) begin
      hold_cnt <= '0;
    end else if (take) begin
      hold_cnt <= '0;
    end else if (state == GRANT && !release_c && hold_cnt != HOLD_LIM) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  assign forced = 1'b0;
`endif

  // A new grant is installed from IDLE or on any release/forced cycle.
  assign take = win_found && ((state == IDLE) || release_c || forced);

  always_ff @(posedge arb_clk or negedge arb_rst_n) begin
    if (!arb_rst_n) begin
      state       <= IDLE;
      arb_gnt_vld <= 1'b0;
      arb_gnt_oh  <= '0;
      arb_gnt_id  <= '0;
      pointer     <= IW'(N - 1);
      arb_preempt <= 1'b0;
    end else begin
      arb_preempt <= forced && take;
      if (take) begin
        state       <= GRANT;
        arb_gnt_vld <= 1'b1;
        arb_gnt_oh  <= win_oh;
        arb_gnt_id  <= win_idx;
        pointer     <= win_idx;
      end else if (release_c) begin
        state       <= IDLE;
        arb_gnt_vld <= 1'b0;
        arb_gnt_oh  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// tb_rr_lock_arbiter -- directed and randomized bench for rr_lock_arbiter.
// Main instance: N=4, HOLD_MAX=4. Second instance: N=3 for wrap/reset cases.
module tb_rr_lock_arbiter;

  localparam int NA   = 4;
  localparam int HOLD = 4;
`ifdef RR_ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic       vld;
  logic [3:0] oh;
  logic [1:0] id;
  logic [1:0] ptr;
  logic       pre;

  logic       rst3_n;
  logic [2:0] req3;
  logic       done3;
  logic       vld3;
  logic [2:0] oh3;
  logic [1:0] id3;
  logic [1:0] ptr3;
  logic       pre3;

  rr_lock_arbiter #(.N(NA), .HOLD_MAX(HOLD)) dut (
    .arb_clk     (clk),
    .arb_rst_n   (rst_n),
    .arb_req     (req),
    .arb_done    (done),
    .arb_gnt_vld (vld),
    .arb_gnt_oh  (oh),
    .arb_gnt_id  (id),
    .pointer     (ptr),
    .arb_preempt (pre)
  );

  rr_lock_arbiter #(.N(3), .HOLD_MAX(HOLD)) dut3 (
    .arb_clk     (clk),
    .arb_rst_n   (rst3_n),
    .arb_req     (req3),
    .arb_done    (done3),
    .arb_gnt_vld (vld3),
    .arb_gnt_oh  (oh3),
    .arb_gnt_id  (id3),
    .pointer     (ptr3),
    .arb_preempt (pre3)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state: owner, last winner, cycles held, preempt pulse.
  int m_vld, m_id, m_ptr, m_cnt, m_pre;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 1; k <= NA; k++) begin
      if (r[(p + k) % NA]) return (p + k) % NA;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_vld = 0; m_id = 0; m_ptr = NA - 1; m_cnt = 0; m_pre = 0;
  endtask

  task automatic model_step();
    int  w;
    bit  rel, frc;
    m_pre = 0;
    if (m_vld == 0) begin
      w = pick(req, m_ptr);
      if (w >= 0) begin
        m_vld = 1; m_id = w; m_ptr = w; m_cnt = 0;
      end
    end else begin
      rel = done || !req[m_id];
      frc = TMO && !rel && (m_cnt == HOLD - 1) && ((req & ~(4'b1 << m_id)) != 4'b0);
      if (rel || frc) begin
        w = pick(req, m_ptr);
        if (w >= 0) begin
          m_id = w; m_ptr = w; m_cnt = 0; m_pre = frc ? 1 : 0;
        end else begin
          m_vld = 0;
        end
      end else if (m_cnt < HOLD - 1) begin
        m_cnt++;
      end
    end
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    chk({tag, ".vld"}, int'(vld), m_vld);
    chk({tag, ".oh"},  int'(oh),  (m_vld != 0) ? (1 << m_id) : 0);
    chk({tag, ".id"},  int'(id),  m_id);
    chk({tag, ".ptr"}, int'(ptr), m_ptr);
    chk({tag, ".pre"}, int'(pre), m_pre);
  endtask

  initial begin
    int exp_seq [6] = '{0, 1, 2, 3, 0, 1};

    rst_n = 1'b0; req = '0; done = 1'b0;
    rst3_n = 1'b0; req3 = '0; done3 = 1'b0;
    model_reset();
    #12;
    chk("rst.vld", int'(vld), 0);
    chk("rst.oh",  int'(oh),  0);
    chk("rst.id",  int'(id),  0);
    chk("rst.ptr", int'(ptr), 3);
    chk("rst.pre", int'(pre), 0);

    // First grant one edge after reset release.
    req = 4'b1010; rst_n = 1'b1;
    tick("first");
    chk("first.id_c",  int'(id),  1);
    chk("first.oh_c",  int'(oh),  2);
    chk("first.ptr_c", int'(ptr), 1);

    // Lock: owner 1 holds while requester 3 waits.
    for (int i = 0; i < 10; i++) begin
      tick("lock");
      if (!TMO) chk("lock.id_c", int'(id), 1);
    end
    req = 4'b1000;
    tick("handover");
    if (!TMO) chk("handover.id_c", int'(id), 3);

    // Fairness and wrap from a fresh reset.
    #3 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    model_reset();
    req = 4'b1111; done = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick("fair");
      chk("fair.seq", int'(id), exp_seq[i]);
    end

    // Re-grant of a lone owner, then idle.
    tick("to2");
    chk("to2.id_c", int'(id), 2);
    req = 4'b0100; done = 1'b1;
    tick("regrant");
    chk("regrant.id_c",  int'(id),  2);
    chk("regrant.vld_c", int'(vld), 1);
    req = 4'b0000; done = 1'b0;
    tick("idle");
    chk("idle.vld_c", int'(vld), 0);
    chk("idle.oh_c",  int'(oh),  0);
    chk("idle.id_c",  int'(id),  2);

    // Timeout: owner 0 holds while requester 2 waits.
    req = 4'b0101;
    tick("tmo.start");
    chk("tmo.start.id_c", int'(id), 0);
    if (TMO) begin
      for (int i = 0; i < 3; i++) begin
        tick("tmo.hold");
        chk("tmo.hold.id_c", int'(id), 0);
      end
      tick("tmo.force");
      chk("tmo.force.id_c",  int'(id),  2);
      chk("tmo.force.pre_c", int'(pre), 1);
      tick("tmo.after");
      chk("tmo.after.pre_c", int'(pre), 0);
    end else begin
      for (int i = 0; i < 20; i++) begin
        tick("notmo.hold");
        chk("notmo.hold.id_c", int'(id), 0);
      end
    end
    req = 4'b0000;
    tick("tmo.end");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      req  = 4'($urandom);
      done = ($urandom_range(0, 3) == 0);
      tick("rand");
    end

    // Asynchronous reset in the middle of a grant.
    req = 4'b0000; done = 1'b0;
    tick("pre_rst.idle");
    req = 4'b0010;
    tick("pre_rst.grant");
    #3 rst_n = 1'b0;
    #1;
    chk("arst.vld", int'(vld), 0);
    chk("arst.oh",  int'(oh),  0);
    chk("arst.id",  int'(id),  0);
    chk("arst.ptr", int'(ptr), 3);
    chk("arst.pre", int'(pre), 0);
    model_reset();
    req = 4'b0000;
    #1 rst_n = 1'b1;

    // N=3: wrap past the top index and async reset.
    @(posedge clk); #1;
    rst3_n = 1'b1; req3 = 3'b100;
    @(posedge clk); #1;
    chk("n3.first.id",  int'(id3),  2);
    chk("n3.first.ptr", int'(ptr3), 2);
    chk("n3.first.vld", int'(vld3), 1);
    req3 = 3'b101; done3 = 1'b1;
    @(posedge clk); #1;
    chk("n3.wrap.id",  int'(id3),  0);
    chk("n3.wrap.oh",  int'(oh3),  1);
    chk("n3.wrap.ptr", int'(ptr3), 0);
    done3 = 1'b0;
    #3 rst3_n = 1'b0;
    #1;
    chk("n3.arst.vld", int'(vld3), 0);
    chk("n3.arst.oh",  int'(oh3),  0);
    chk("n3.arst.id",  int'(id3),  0);
    chk("n3.arst.ptr", int'(ptr3), 2);
    chk("n3.arst.pre", int'(pre3), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_lock_arbiter.md
# rr_lock_arbiter

Parametrised N-way round-robin arbiter with grant locking. It is the successor to the fixed 4-requester rotating arbiter. Instead of a free-running pointer, rotation follows the last winner. Once a requester is granted, it keeps the grant across a multi-cycle transfer until it drops its request or signals completion. It sits in front of any shared single-owner resource (bus port, memory bank, shared FIFO write side).

## Interface
- `N`, default 4: number of requesters, legal range 2..32, need not be a power of two.
- `HOLD_MAX`, default 16: maximum cycles one owner may hold the grant while others wait. Used only when `RR_ARB_TIMEOUT_EN` is defined; legal range 2..255.
- `IW`: derived local parameter, `$clog2(N)`.

Ports:
- `arb_clk`, in, 1: clock, all logic on the rising edge.
- `arb_rst_n`, in, 1: reset, asynchronous, active-low.
- `arb_req`, in, N: request vector, bit i = requester i.
- `arb_done`, in, 1: current owner's last beat this cycle; qualified only while `arb_gnt_vld` = 1.
- `arb_gnt_vld`, out, 1: a grant is active.
- `arb_gnt_oh`, out, N: one-hot grant; all zero when `arb_gnt_vld` = 0.
- `arb_gnt_id`, out, IW: encoded owner; holds the last value when idle.
- `pointer`, out, IW: index of the most recent winner; the search starts at `pointer`+1.
- `arb_preempt`, out, 1: one-cycle pulse when a grant is forcibly ended by timeout; constant 0 without the macro.

## Operation
State machine with two states, IDLE and GRANT.

**Reset values:** state IDLE, `arb_gnt_vld` 0, `arb_gnt_oh` 0, `arb_gnt_id` 0, `pointer` N-1 (so the first search starts at requester 0), `arb_preempt` 0, hold counter 0.

**Pick function:** the winner is the first set bit of `arb_req` scanning `pointer`+1, `pointer`+2, … modulo N, wrapping from N-1 to 0. The current `pointer` index is checked last.

**IDLE:**
- If `arb_req` is nonzero, register the winner on the next edge: `arb_gnt_vld` 1, `arb_gnt_oh`/`arb_gnt_id` = winner, `pointer` = winner, state GRANT.
- If `arb_req` is zero, remain in IDLE.

**GRANT:** a release occurs in a cycle where `arb_done` = 1 or `arb_req[arb_gnt_id]` = 0.
- With no release, all outputs hold.
- On a release cycle, re-arbitrate in the same cycle, with `pointer` equal to the current owner:
  - If any request is pending, the new grant is registered on the next edge (back-to-back, no idle gap) and `pointer` updates.
  - If the owner asserted `arb_done` but still requests and nobody else does, the owner is re-granted.
  - If no request is pending, go to IDLE with `arb_gnt_vld` 0 and `arb_gnt_oh` 0.

**Other rules:**
- Requests from non-owners never disturb an active grant, unless the timeout feature is compiled in.
- `arb_done` while in IDLE is ignored.
- Reset asserted mid-grant forces reset values immediately (asynchronously); no grant survives reset.

## Timing
- Request to grant is 1 cycle from IDLE. The handover is 1 cycle: the release cycle is the owner's last cycle and the next owner is visible on the following edge.
- Grant outputs are registered; no combinational path from `arb_req` to any output.
- `pointer` changes only on the edge that installs a new grant, including a re-grant to the same requester.

## Configuration
`RR_ARB_TIMEOUT_EN` adds an 8-bit hold counter and bounds how long one owner can keep the grant.

**Defined:**
- The counter clears on every new grant and increments each GRANT cycle without release.
- When the counter equals `HOLD_MAX`-1 and any non-owner request is pending, a forced release occurs:
  - re-arbitration runs with the owner lowest priority;
  - `arb_preempt` pulses for the cycle in which the new grant appears.
- With no other requester pending, the counter saturates and the owner keeps the grant.

**Undefined:**
- No counter is built, `HOLD_MAX` is ignored and `arb_preempt` is tied 0.
- The grant is held indefinitely until release.

## Structure
- Package `rr_arb_pkg` holds the state enum (IDLE, GRANT), the counter width constant (8), and a helper function for the one-hot-to-index conversion.
- One combinational sub-module, `rr_arb_pick`, parametrised by N. It takes the request vector and the pointer and returns a found flag, the winner index and a one-hot winner. The top-level FSM, registers and timeout logic live in `rr_lock_arbiter`.

## Test plan
All scenarios use N=4 unless stated otherwise.
- **Reset and first grant:** release reset with `arb_req`=4'b1010 → one edge later `arb_gnt_id`=1, `arb_gnt_oh`=4'b0010, `pointer`=1.
- **Lock:** owner 1 holds its request for 10 cycles while `arb_req[3]`=1 → grant stays 1. Drop `arb_req[1]` → next edge `arb_gnt_id`=3, no idle cycle.
- **Fairness/wrap:** hold `arb_req`=4'b1111 and pulse `arb_done` every cycle → grants go 0,1,2,3,0,1 in order, with the wrap from 3 to 0.
- **Re-grant and idle:** owner 2 pulses `arb_done` with only `arb_req[2]` high → re-granted 2. Then all requests drop → `arb_gnt_vld`=0 and `arb_gnt_oh`=0 one edge later, `arb_gnt_id` holds 2.
- **Timeout** (macro defined, `HOLD_MAX`=4): owner 0 holds its request, `arb_req[2]` is high → after 4 grant cycles `arb_gnt_id`=2 and `arb_preempt` pulses once. Without the macro, owner 0 keeps the grant for 20+ cycles.
- **Non-power-of-two and reset:** N=3, `arb_req`=3'b101 with owner 2 releasing → the next grant is 0. Assert reset mid-grant → all outputs return to reset values immediately.
